maze_move_ctrl: RTL
===================

MAZE_MOVE_CTRL -- requirements
Module: maze_move_ctrl

Interface
REQ-001 Parameter GRID_W, default 20, maze width in cells (640/32).
REQ-002 Parameter GRID_H, default 15, maze height in cells (480/32).
REQ-003 Parameters START_X/START_Y, defaults 1/1, player reset cell.
REQ-004 Parameters GOAL_X/GOAL_Y, defaults 18/13, goal cell.
REQ-005 Port list:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- move_req  in  4  one-cycle move pulses {up, down, left, right}, from the debounced single-pulse button outputs.
- player_x_pos  out  8  current player column.
- player_y_pos  out  8  current player row.
- busy  out  1  a move is being evaluated.
- bump  out  1  one-cycle pulse; move rejected (wall or edge).
- won  out  1  player has reached the goal; sticky.
- move_bcd  out  16  accepted-move count, 4 BCD digits, for the SSD.

Function
REQ-006 FSM states SHALL be IDLE, LOOKUP, CHECK and WON.
REQ-007 In IDLE, any nonzero move_req SHALL be accepted.
- Priority when several bits are set: up > down > left > right; lower-priority bits are discarded.
REQ-008 Target cell on acceptance:
- up: y-1; down: y+1; left: x-1; right: x+1.
- Arithmetic SHALL be 9-bit signed, so that an underflow is detectable.
REQ-009 Target out of range (x<0, y<0, x>=GRID_W or y>=GRID_H): the block SHALL stay in IDLE, pulse bump in the next cycle, leave position unchanged and perform no ROM read.
REQ-010 Valid target: the block SHALL register the target, register rom_addr = ty*GRID_W+tx, and enter LOOKUP.
REQ-011 LOOKUP SHALL last exactly one cycle, then go to CHECK; ROM data is valid in CHECK (synchronous ROM, 1-cycle latency).
REQ-012 In CHECK, if the wall bit is 1:
- position unchanged;
- bump pulses in the following cycle;
- next state IDLE.
REQ-013 In CHECK, if the wall bit is 0:
- position takes the target cell;
- move_bcd increments;
- next state WON if the target equals the goal, else IDLE.
REQ-014 Timing: a request in cycle 0 SHALL give busy=1 in cycles 1–2 and the updated position/bump/won visible in cycle 3; one move per 3 cycles at most.
REQ-015 move_req SHALL be ignored while in LOOKUP, CHECK or WON; pulses arriving then are dropped, not queued.
REQ-016 move_bcd SHALL count in BCD with per-digit carry (0009→0010, 0099→0100) and saturate at 9999.
REQ-017 WON SHALL be absorbing until reset: won=1, busy=0, position frozen.
REQ-018 bump SHALL never be high in two consecutive cycles for one request.

Reset
REQ-019 On asynchronous reset assertion, without waiting for clk, outputs SHALL take:
- player_x_pos=START_X, player_y_pos=START_Y;
- busy=0, bump=0, won=0, move_bcd=0;
- state=IDLE.
REQ-020 Reset asserted mid-move (LOOKUP/CHECK) SHALL abandon the move with no position or count update.
REQ-021 The first request SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-022 A shared package maze_pkg SHALL hold:
- state encoding;
- grid default constants;
- the MAZE_MAP constant (GRID_W*GRID_H bits, row-major, 1=wall).
REQ-023 MAZE_MAP SHALL mark every border cell and cell (3,1) as wall, and keep cells (2,1) and (1,2) open.
REQ-024 One sub-module, maze_wall_rom, SHALL be instantiated: synchronous 1-bit read of MAZE_MAP, address width ceil(log2(GRID_W*GRID_H)), no reset on its data register.
REQ-025 The pixel renderer SHALL read MAZE_MAP through its own ROM instance; the two SHALL share no read port.

Verification
REQ-026 Reset, then move_req=0001 (right) at cycle 0 -> busy high in cycles 1–2, position (2,1) in cycle 3, move_bcd=0x0001, bump=0.
REQ-027 From (2,1), right -> (3,1) is a wall: position stays (2,1), bump high for exactly cycle 3, move_bcd unchanged.
REQ-028 move_req=1010 (up+left) from (1,1) -> up wins; target (1,0) is a border wall -> bump, position (1,1).
REQ-029 Pulse right in cycle 1 of an ongoing move -> the pulse is dropped; only one move is counted.
REQ-030 Force position (17,13) via the test map, then right -> position (18,13), won=1; further requests have no effect.
REQ-031 Count preload/accept 9999 moves, then one more move -> move_bcd=0x9999; assert reset during CHECK -> (1,1), move_bcd=0x0000 immediately.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared FSM encoding, grid defaults, maze wall map and BCD helper
package maze_pkg;
    typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, WON} state_t;
    localparam int GRID_W_DEF = 20;
    localparam int GRID_H_DEF = 15;
    localparam int MAP_BITS = GRID_W_DEF * GRID_H_DEF;
    function automatic logic [MAP_BITS-1:0] build_map();
        logic [MAP_BITS-1:0] m;
        m = '0;
        for (int y = 0; y < GRID_H_DEF; y++)
            for (int x = 0; x < GRID_W_DEF; x++)
                if (x == 0 || y == 0 || x == GRID_W_DEF - 1 || y == GRID_H_DEF - 1)
                    m[y * GRID_W_DEF + x] = 1'b1;
        m[1 * GRID_W_DEF + 3] = 1'b1;
        return m;
    endfunction
    localparam logic [MAP_BITS-1:0] MAZE_MAP = build_map();
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic c;
        r = v;
        c = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++)
            if (c) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        return r;
    endfunction
endpackage

// File: rtl/maze_move_ctrl_if.sv
// maze_move_ctrl_if: move request in, player position and status out
interface maze_move_ctrl_if;
    logic [3:0]  move_req;
    logic [7:0]  player_x_pos;
    logic [7:0]  player_y_pos;
    logic        busy;
    logic        bump;
    logic        won;
    logic [15:0] move_bcd;
    modport master (output move_req, input player_x_pos, player_y_pos, busy, bump, won, move_bcd);
    modport slave  (input move_req, output player_x_pos, player_y_pos, busy, bump, won, move_bcd);
endinterface

// File: rtl/maze_wall_rom.sv
// maze_wall_rom: synchronous 1-bit wall lookup into the maze map
module maze_wall_rom import maze_pkg::*; #(
    parameter int DEPTH = MAP_BITS,
    parameter logic [DEPTH-1:0] MAP = MAZE_MAP,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic          wall_o
);
    // registered read, data valid one cycle after the address
    always_ff @(posedge clk) wall_o <= MAP[addr_i];
endmodule

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: validates button moves against the maze and tracks player/goal/count
module maze_move_ctrl import maze_pkg::*; #(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int START_X = 1,
    parameter int START_Y = 1,
    parameter int GOAL_X  = 18,
    parameter int GOAL_Y  = 13
) (
    input logic clk,
    input logic reset,
    maze_move_ctrl_if.slave bus
);
    localparam int AW = $clog2(GRID_W * GRID_H);
    localparam logic signed [8:0] GW = 9'(GRID_W);
    localparam logic signed [8:0] GH = 9'(GRID_H);
    localparam logic [7:0] SX = 8'(START_X);
    localparam logic [7:0] SY = 8'(START_Y);
    localparam logic [7:0] GX = 8'(GOAL_X);
    localparam logic [7:0] GY = 8'(GOAL_Y);
    state_t state_q, state_d;
    logic [7:0] px_q, px_d, py_q, py_d, tx_q, tx_d, ty_q, ty_d;
    logic [AW-1:0] addr_q, addr_d;
    logic bump_q, bump_d;
    logic [15:0] bcd_q, bcd_d;
    logic signed [8:0] nx, ny;
    logic in_range, wall;
    logic [3:0] mr;
    assign mr = bus.move_req;
    // signed target so a step off the low edge shows up as negative
    always_comb begin
        nx = $signed({1'b0, px_q}) + (mr[3] | mr[2] ? 9'sd0 : mr[1] ? -9'sd1 : mr[0] ? 9'sd1 : 9'sd0);
        ny = $signed({1'b0, py_q}) + (mr[3] ? -9'sd1 : mr[2] ? 9'sd1 : 9'sd0);
        in_range = !nx[8] && !ny[8] && nx < GW && ny < GH;
    end
    // move FSM: accept in IDLE, wait out the ROM read, then commit or bump
    always_comb begin
        state_d = state_q;
        px_d = px_q;
        py_d = py_q;
        tx_d = tx_q;
        ty_d = ty_q;
        addr_d = addr_q;
        bump_d = 1'b0;
        bcd_d = bcd_q;
        case (state_q)
            IDLE: if (|mr) begin
                if (in_range) begin
                    tx_d = nx[7:0];
                    ty_d = ny[7:0];
                    addr_d = AW'(int'(ny[7:0]) * GRID_W + int'(nx[7:0]));
                    state_d = LOOKUP;
                end else bump_d = 1'b1;
            end
            LOOKUP: state_d = CHECK;
            CHECK: if (wall) begin
                bump_d = 1'b1;
                state_d = IDLE;
            end else begin
                px_d = tx_q;
                py_d = ty_q;
                bcd_d = bcd_inc(bcd_q);
                state_d = (tx_q == GX && ty_q == GY) ? WON : IDLE;
            end
            default: ;
        endcase
    end
    // state and datapath registers, async reset abandons any move in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            px_q <= SX;
            py_q <= SY;
            tx_q <= '0;
            ty_q <= '0;
            addr_q <= '0;
            bump_q <= 1'b0;
            bcd_q <= '0;
        end else begin
            state_q <= state_d;
            px_q <= px_d;
            py_q <= py_d;
            tx_q <= tx_d;
            ty_q <= ty_d;
            addr_q <= addr_d;
            bump_q <= bump_d;
            bcd_q <= bcd_d;
        end
    end
    maze_wall_rom #(.DEPTH(GRID_W * GRID_H)) u_rom (.clk(clk), .addr_i(addr_q), .wall_o(wall));
    assign bus.player_x_pos = px_q;
    assign bus.player_y_pos = py_q;
    assign bus.busy = state_q == LOOKUP || state_q == CHECK;
    assign bus.bump = bump_q;
    assign bus.won = state_q == WON;
    assign bus.move_bcd = bcd_q;
endmodule
